// File: rtl/fetch_align_if.sv
// Handshake bundle between the fetch alignment buffer, instruction memory,
// the redirect source and the downstream decompressor.
interface fetch_align_if;
  logic        redirect;
  logic [31:1] redirect_pc;
  logic        fetch_req;
  logic [31:2] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:1] instr_pc;
  logic        instr_ready;

  modport slave (
    input  redirect, redirect_pc, fetch_gnt, fetch_rvalid, fetch_rdata, instr_ready,
    output fetch_req, fetch_addr, instr_valid, instr_out, instr_pc
  );

  modport master (
    output redirect, redirect_pc, fetch_gnt, fetch_rvalid, fetch_rdata, instr_ready,
    input  fetch_req, fetch_addr, instr_valid, instr_out, instr_pc
  );
endinterface

// File: rtl/fetch_align.sv
// Fetch alignment buffer: word fetches into a 4-halfword queue, one whole
// 16- or 32-bit instruction presented per handshake, flushed on redirect.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_align_if.slave bus
);
  logic [15:0] hbuf     [4];
  logic [15:0] hbuf_nxt [4];
  logic [2:0]  count_q;
  logic [2:0]  count_nxt;
  logic [2:0]  base;
  logic [31:1] head_pc_q;
  logic [31:2] next_fetch_q;
  logic        pending_q;
  logic        drop_low_q;
  logic        stale_q;
  logic        head_comp;
  logic        handshake;
  logic        grant;
  logic        accept;
  logic [1:0]  consumed;
  logic [1:0]  appended;
  logic [15:0] first_hw;

  assign head_comp       = hbuf[0][1:0] != 2'b11;
  assign bus.instr_valid = (count_q >= 3'd2) || ((count_q == 3'd1) && head_comp);
  assign bus.instr_out   = {((!head_comp) || (count_q >= 3'd2)) ? hbuf[1] : 16'h0000, hbuf[0]};
  assign bus.instr_pc    = head_pc_q;
  assign bus.fetch_req   = !rst && !pending_q && (count_q <= 3'd2);
  assign bus.fetch_addr  = next_fetch_q;

  // A redirect cycle swallows both the downstream handshake and any response.
  assign grant     = bus.fetch_req && bus.fetch_gnt;
  assign handshake = bus.instr_valid && bus.instr_ready && !bus.redirect;
  assign accept    = bus.fetch_rvalid && !stale_q && !bus.redirect;
  assign consumed  = handshake ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
  assign appended  = accept ? (drop_low_q ? 2'd1 : 2'd2) : 2'd0;
  assign base      = count_q - {1'b0, consumed};
  assign count_nxt = base + {1'b0, appended};
  assign first_hw  = drop_low_q ? bus.fetch_rdata[31:16] : bus.fetch_rdata[15:0];

  always_comb begin
    hbuf_nxt = hbuf;
    if (consumed == 2'd1) begin
      hbuf_nxt = '{hbuf[1], hbuf[2], hbuf[3], 16'h0000};
    end else if (consumed == 2'd2) begin
      hbuf_nxt = '{hbuf[2], hbuf[3], 16'h0000, 16'h0000};
    end
    // New halfwords land behind whatever survives the shift.
    if ((appended != 2'd0) && (base < 3'd4)) begin
      hbuf_nxt[base[1:0]] = first_hw;
    end
    if ((appended == 2'd2) && (base < 3'd3)) begin
      hbuf_nxt[base[1:0] + 2'd1] = bus.fetch_rdata[31:16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hbuf         <= '{default: 16'h0000};
      count_q      <= 3'd0;
      pending_q    <= 1'b0;
      // A grant still in flight must not leak its response into the new stream.
      stale_q      <= pending_q && !bus.fetch_rvalid;
      head_pc_q    <= RESET_PC[31:1];
      next_fetch_q <= RESET_PC[31:2];
      drop_low_q   <= RESET_PC[1];
    end else begin
      if (grant) begin
        pending_q <= 1'b1;
      end else if (bus.fetch_rvalid) begin
        pending_q <= 1'b0;
      end

      if (bus.redirect) begin
        count_q      <= 3'd0;
        head_pc_q    <= bus.redirect_pc;
        next_fetch_q <= bus.redirect_pc[31:2];
        drop_low_q   <= bus.redirect_pc[1];
        stale_q      <= (pending_q && !bus.fetch_rvalid) || grant;
      end else begin
        hbuf    <= hbuf_nxt;
        count_q <= count_nxt;
        if (handshake) begin
          head_pc_q <= head_pc_q + 31'(consumed);
        end
        if (grant) begin
          next_fetch_q <= next_fetch_q + 30'd1;
        end
        if (bus.fetch_rvalid) begin
          stale_q <= 1'b0;
        end
        if (accept) begin
          drop_low_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align with a small in-order memory responder
// whose response latency can be changed between steps.
module tb_fetch_align;
  logic clk = 1'b0;
  logic rst;

  fetch_align_if bus ();

  fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  logic [29:0] gaddr[$];
  logic [31:0] mem [256];
  int          cyc_n   = 0;
  int          lat     = 1;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          gnt_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock: memory grants any request at once and answers `lat` cycles later.
  task automatic tick();
    bus.fetch_gnt    = 1'b0;
    bus.fetch_rvalid = 1'b0;
    bus.fetch_rdata  = '0;
    gnt_seen         = 1'b0;
    #1;
    if (bus.fetch_req) begin
      bus.fetch_gnt = 1'b1;
      gnt_seen      = 1'b1;
      gaddr.push_back(bus.fetch_addr);
      rq.push_back('{bus.fetch_addr, cyc_n + lat});
    end
    if ((rq.size() > 0) && (rq[0].due <= cyc_n)) begin
      bus.fetch_rvalid = 1'b1;
      bus.fetch_rdata  = mem[rq[0].addr[7:0]];
      void'(rq.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] ei, input logic [31:1] ep);
    int k = 0;
    while (!bus.instr_valid && (k < 20)) begin
      tick();
      k++;
    end
    chk({tag, "_wait"}, 32'(k < 20), 32'd1);
    chk({tag, "_instr"}, bus.instr_out, ei);
    chk({tag, "_pc"}, 32'(bus.instr_pc), 32'(ep));
    tick();
  endtask

  function automatic logic [31:0] first_gnt();
    return (gaddr.size() > 0) ? 32'(gaddr[0]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst              = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.instr_ready  = 1'b1;
    bus.fetch_gnt    = 1'b0;
    bus.fetch_rvalid = 1'b0;
    bus.fetch_rdata  = '0;
    @(negedge clk);

    // Reset state and an aligned 32-bit stream
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    tick();
    chk("rst_req", 32'(bus.fetch_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_out", bus.instr_out, 32'h0);
    chk("rst_pc", 32'(bus.instr_pc), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t1_req", 32'(bus.fetch_req), 32'd1);
    chk("t1_addr", 32'(bus.fetch_addr), 32'h0);
    gaddr.delete();
    expect_instr("t1a", 32'h0050_0093, 31'h0);
    expect_instr("t1b", 32'h00A0_0113, 31'h2);
    chk("t1_ngnt", 32'(gaddr.size() >= 2), 32'd1);
    chk("t1_gnt0", first_gnt(), 32'h0);
    chk("t1_gnt1", (gaddr.size() >= 2) ? 32'(gaddr[1]) : 32'hFFFF_FFFF, 32'h1);

    // Compressed / straddling 32-bit / compressed
    rst    = 1'b1;
    mem[0] = 32'h0093_4501;
    mem[1] = 32'h4585_0050;
    tick();
    tick();
    rst = 1'b0;
    expect_instr("t2_c1", 32'h0093_4501, 31'h0);
    expect_instr("t2_str", 32'h0050_0093, 31'h1);
    expect_instr("t2_c2", 32'h0000_4585, 31'h3);

    // Redirect to an odd halfword: low half of the word is dropped
    mem[8'h40]      = 32'h4505_FFFF;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 31'h81;
    tick();
    bus.redirect = 1'b0;
    gaddr.delete();
    expect_instr("t3", 32'h0000_4505, 31'h81);
    chk("t3_addr", first_gnt(), 32'h40);

    // Redirect while a fetch from address 0 is outstanding
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    lat = 3;
    #1;
    chk("t4_req", 32'(bus.fetch_req), 32'd1);
    chk("t4_addr0", 32'(bus.fetch_addr), 32'h0);
    tick();
    mem[8'h80]      = 32'h00C0_0193;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 31'h100;
    tick();
    bus.redirect = 1'b0;
    gaddr.delete();
    expect_instr("t4", 32'h00C0_0193, 31'h100);
    chk("t4_addr", first_gnt(), 32'h80);
    lat = 1;

    // Backpressure with compressed-only data
    mem[8'hC0]      = 32'h0005_0001;
    mem[8'hC1]      = 32'h000D_0009;
    mem[8'hC2]      = 32'h0015_0011;
    mem[8'hC3]      = 32'h001D_0019;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 31'h180;
    tick();
    bus.redirect = 1'b0;
    gaddr.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.instr_valid) chk("t5_stable", bus.instr_out, 32'h0005_0001);
    end
    chk("t5_req", 32'(bus.fetch_req), 32'd0);
    chk("t5_valid", 32'(bus.instr_valid), 32'd1);
    chk("t5_pc", 32'(bus.instr_pc), 32'h180);
    chk("t5_ngnt", 32'(gaddr.size()), 32'd2);
    bus.instr_ready = 1'b1;
    expect_instr("t5_0", 32'h0005_0001, 31'h180);
    expect_instr("t5_1", 32'h0009_0005, 31'h181);
    expect_instr("t5_2", 32'h000D_0009, 31'h182);
    expect_instr("t5_3", 32'h0000_000D, 31'h183);
    expect_instr("t5_4", 32'h0015_0011, 31'h184);
    expect_instr("t5_5", 32'h0000_0015, 31'h185);

    // Reset for one cycle with a grant outstanding
    lat    = 2;
    mem[0] = 32'h0050_0093;
    k      = 0;
    do begin
      tick();
      k++;
    end while (!gnt_seen && (k < 10));
    chk("t6_gnt", 32'(gnt_seen), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_valid0", 32'(bus.instr_valid), 32'd0);
    chk("t6_req", 32'(bus.fetch_req), 32'd1);
    chk("t6_addr", 32'(bus.fetch_addr), 32'h0);
    gaddr.delete();
    tick();
    chk("t6_late", 32'(bus.instr_valid), 32'd0);
    expect_instr("t6", 32'h0050_0093, 31'h0);
    chk("t6_gnt0", first_gnt(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
